// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag/abort detection, zero removal, an 8-bit-time
// delay line that keeps the closing flag away from the byte assembler,
// byte assembly (LSB first) and end-of-frame / abort / frame-error status.
module hdlc_rx_deframer #(
    parameter int ZERO_RUN       = 5,  // 1s after which a following 0 is removed
    parameter int ABORT_RUN      = 7,  // 1s after a 0 that form an abort (max 7)
    parameter int MIN_FRAME_BITS = 8   // shorter frames are treated as repeated flags
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx,
    input  logic       RxEN,
    output logic       Rx_FlagDetect,
    output logic       Rx_AbortDetect,
    output logic       Rx_ValidFrame,
    output logic       Rx_NewByte,
    output logic [7:0] Rx_Data,
    output logic       Rx_EoF,
    output logic       Rx_AbortSignal,
    output logic       Rx_FrameError
);

    localparam logic [7:0] FLAG_PATTERN = 8'h7E;

    typedef enum logic [1:0] {IDLE, OPEN, FRAME} state_t;

    // Sampling stage: newest bit at shift_reg[0]
    logic [7:0] shift_reg;
    logic       in_valid_reg;   // shift_reg[0] is a freshly sampled bit
    logic [2:0] ones_reg;       // consecutive 1s seen on Rx (saturating)
    logic       stuff_reg;      // shift_reg[0] is an inserted zero
    logic       flag_det_reg;
    logic       abort_det_reg;

    // Frame tracking and data path
    state_t     state_reg;
    logic [7:0] dly_reg;        // delay line, oldest bit at dly_reg[7]
    logic [3:0] fill_reg;       // number of valid bits in the delay line
    logic [7:0] asm_reg;
    logic [7:0] bit_cnt_reg;    // destuffed data bits that left the delay line
    logic       min_reached_reg;
    logic       valid_reg;
    logic       eof_pend_reg;
    logic       eof_reg;
    logic       abort_sig_reg;
    logic       frame_err_reg;
    logic [7:0] data_reg;
    logic       new_byte_reg;

    logic       advance;
    logic       flag_hit;
    logic       abort_hit;
    logic       push;
    logic [8:0] cnt_inc;
    logic [7:0] asm_next;

    assign advance   = RxEN && in_valid_reg;
    assign flag_hit  = advance && (shift_reg == FLAG_PATTERN);
    // A 0 followed by ABORT_RUN 1s; longer runs shift the 0 out, so one hit per run
    assign abort_hit = advance && !shift_reg[ABORT_RUN] && (&shift_reg[ABORT_RUN-1:0]);
    // In IDLE the bit behind an opening flag is already the first data bit
    assign push      = advance && !stuff_reg && ((state_reg != IDLE) || flag_det_reg);
    assign cnt_inc   = {1'b0, bit_cnt_reg} + 9'd1;
    assign asm_next  = {dly_reg[7], asm_reg[7:1]};

    // Bit sampling, ones counting, stuffed-zero marking and pattern detection
    always_ff @(posedge Clk) begin
        if (Rst) begin
            shift_reg     <= 8'hFF;
            in_valid_reg  <= 1'b0;
            ones_reg      <= 3'd0;
            stuff_reg     <= 1'b0;
            flag_det_reg  <= 1'b0;
            abort_det_reg <= 1'b0;
        end else begin
            in_valid_reg  <= RxEN;
            flag_det_reg  <= flag_hit;
            abort_det_reg <= abort_hit;
            if (RxEN) begin
                shift_reg <= {shift_reg[6:0], Rx};
                stuff_reg <= !Rx && (ones_reg == 3'(ZERO_RUN));
                if (Rx) begin
                    ones_reg <= (ones_reg == 3'd7) ? 3'd7 : ones_reg + 3'd1;
                end else begin
                    ones_reg <= 3'd0;
                end
            end
        end
    end

    // Frame FSM with delay line, byte assembly and registered status outputs
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg       <= IDLE;
            dly_reg         <= 8'h00;
            fill_reg        <= 4'd0;
            asm_reg         <= 8'h00;
            bit_cnt_reg     <= 8'd0;
            min_reached_reg <= 1'b0;
            valid_reg       <= 1'b0;
            eof_pend_reg    <= 1'b0;
            eof_reg         <= 1'b0;
            abort_sig_reg   <= 1'b0;
            frame_err_reg   <= 1'b0;
            data_reg        <= 8'h00;
            new_byte_reg    <= 1'b0;
        end else begin
            new_byte_reg <= 1'b0;
            eof_pend_reg <= 1'b0;
            eof_reg      <= eof_pend_reg;
            if (!RxEN) begin
                // Receiver disabled: silently drop any open frame
                state_reg       <= IDLE;
                valid_reg       <= 1'b0;
                fill_reg        <= 4'd0;
                bit_cnt_reg     <= 8'd0;
                min_reached_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (flag_det_reg) begin
                            state_reg       <= OPEN;
                            valid_reg       <= 1'b1;
                            abort_sig_reg   <= 1'b0;
                            frame_err_reg   <= 1'b0;
                            dly_reg         <= {dly_reg[6:0], shift_reg[0]};
                            fill_reg        <= push ? 4'd1 : 4'd0;
                            bit_cnt_reg     <= 8'd0;
                            min_reached_reg <= 1'b0;
                        end
                    end
                    OPEN, FRAME: begin
                        if (abort_det_reg) begin
                            state_reg     <= IDLE;
                            valid_reg     <= 1'b0;
                            abort_sig_reg <= 1'b1;
                            eof_pend_reg  <= 1'b1;
                            fill_reg      <= 4'd0;
                        end else if (flag_det_reg) begin
                            if (!min_reached_reg) begin
                                // Too short to be a frame: treat as a new opening flag
                                state_reg       <= OPEN;
                                dly_reg         <= {dly_reg[6:0], shift_reg[0]};
                                fill_reg        <= push ? 4'd1 : 4'd0;
                                bit_cnt_reg     <= 8'd0;
                                min_reached_reg <= 1'b0;
                            end else begin
                                state_reg    <= IDLE;
                                valid_reg    <= 1'b0;
                                eof_pend_reg <= 1'b1;
                                fill_reg     <= 4'd0;
                                if (bit_cnt_reg[2:0] != 3'd0) begin
                                    frame_err_reg <= 1'b1;
                                end
                            end
                        end else if (push) begin
                            dly_reg <= {dly_reg[6:0], shift_reg[0]};
                            if (fill_reg == 4'd8) begin
                                // Oldest bit leaves the delay line as a data bit
                                state_reg   <= FRAME;
                                asm_reg     <= asm_next;
                                bit_cnt_reg <= cnt_inc[7:0];
                                if (cnt_inc >= 9'(MIN_FRAME_BITS)) begin
                                    min_reached_reg <= 1'b1;
                                end
                                if (bit_cnt_reg[2:0] == 3'd7) begin
                                    data_reg     <= asm_next;
                                    new_byte_reg <= 1'b1;
                                end
                            end else begin
                                fill_reg <= fill_reg + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        valid_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Rx_FlagDetect  = flag_det_reg;
    assign Rx_AbortDetect = abort_det_reg;
    assign Rx_ValidFrame  = valid_reg;
    assign Rx_NewByte     = new_byte_reg;
    assign Rx_Data        = data_reg;
    assign Rx_EoF         = eof_reg;
    assign Rx_AbortSignal = abort_sig_reg;
    assign Rx_FrameError  = frame_err_reg;

endmodule
